// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - multi-channel PWM fade sequencer (up / hold / down ramp)
//
// Purpose:
//   Sequences a shared brightness level 0 -> max -> hold -> 0 and drives
//   per-channel PWM compare values scaled by each channel's target. Compare
//   updates are committed only on the last clock of a PWM period so that
//   downstream pwm counters never see a mid-period change.
//
// Build option:
//   PWM_FADE_GAMMA_EN - when defined, the level is squared, (lvl*lvl)>>CTR_LEN,
//                       before scaling, giving a perceptual quadratic fade.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        1-cycle request to begin a fade sequence (ignored while busy)
//   abort        synchronous stop, forces IDLE and zero compare outputs
//   loop         sampled at start; 1 = repeat the sequence until abort
//   target       per-channel peak compare, ch i at [i*CTR_LEN +: CTR_LEN]
//   step_div     level step every step_div+1 PWM periods
//   hold_len     HOLD lasts hold_len+1 PWM periods
//   compare      per-channel compare to the pwm instances, same packing as target
//   period_tick  high on the last clock of each PWM period
//   busy         high in any state except IDLE
//   done         1-cycle pulse when a ramp-down completes

module pwm_fade_ctrl #(
  parameter int CTR_LEN   = 8,
  parameter int NCH       = 3,
  parameter int PRESC_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop,
  input  logic [NCH*CTR_LEN-1:0] target,
  input  logic [PRESC_LEN-1:0]   step_div,
  input  logic [PRESC_LEN-1:0]   hold_len,
  output logic [NCH*CTR_LEN-1:0] compare,
  output logic                   period_tick,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UP,
    ST_HOLD,
    ST_DOWN
  } state_e;

  localparam logic [CTR_LEN-1:0]   LVL_MAX = '1;
  localparam logic [CTR_LEN-1:0]   C_ONE   = {{(CTR_LEN-1){1'b0}}, 1'b1};
  localparam logic [PRESC_LEN-1:0] P_ONE   = {{(PRESC_LEN-1){1'b0}}, 1'b1};
  localparam logic [2*CTR_LEN-1:0] W_ONE   = {{(2*CTR_LEN-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [CTR_LEN-1:0]       pcnt_q;
  logic [CTR_LEN-1:0]       lvl_q, lvl_d;
  logic [PRESC_LEN-1:0]     step_cnt_q, step_cnt_d;
  logic [PRESC_LEN-1:0]     hold_cnt_q, hold_cnt_d;
  logic [NCH*CTR_LEN-1:0]   tgt_q, tgt_d;
  logic [PRESC_LEN-1:0]     sdiv_q, sdiv_d;
  logic [PRESC_LEN-1:0]     hlen_q, hlen_d;
  logic                     loop_q, loop_d;
  logic [NCH*CTR_LEN-1:0]   compare_q, compare_d;
  logic [NCH*CTR_LEN-1:0]   scaled;
  logic [CTR_LEN-1:0]       lvl_s;
  logic                     step_event;
  logic                     done_c;

  // Product is formed at 2*CTR_LEN bits; (lvl+1) reaches 2^CTR_LEN so the
  // top half of target*(lvl+1) equals target exactly at lvl = max.
  function automatic logic [CTR_LEN-1:0] scale_fn(input logic [CTR_LEN-1:0] t,
                                                  input logic [CTR_LEN-1:0] l);
    logic [2*CTR_LEN-1:0] p;
    p = {{CTR_LEN{1'b0}}, t} * ({{CTR_LEN{1'b0}}, l} + W_ONE);
    return CTR_LEN'(p >> CTR_LEN);
  endfunction

`ifdef PWM_FADE_GAMMA_EN
  logic [2*CTR_LEN-1:0] lvl_sq;
  assign lvl_sq = {{CTR_LEN{1'b0}}, lvl_q} * {{CTR_LEN{1'b0}}, lvl_q};
  assign lvl_s  = CTR_LEN'(lvl_sq >> CTR_LEN);
`else
  assign lvl_s  = lvl_q;
`endif

  // Free-running period counter; shares reset with the pwm instances so
  // period boundaries line up with theirs. Abort never stops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + C_ONE;
    end
  end

  assign period_tick = &pcnt_q;
  assign step_event  = period_tick && (step_cnt_q == sdiv_q);

  always_comb begin
    scaled = '0;
    for (int i = 0; i < NCH; i++) begin
      if (state_q != ST_IDLE) begin
        scaled[i*CTR_LEN +: CTR_LEN] = scale_fn(tgt_q[i*CTR_LEN +: CTR_LEN], lvl_s);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    tgt_d      = tgt_q;
    sdiv_d     = sdiv_q;
    hlen_d     = hlen_q;
    loop_d     = loop_q;
    compare_d  = period_tick ? scaled : compare_q;
    done_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tgt_d      = target;
          sdiv_d     = step_div;
          hlen_d     = hold_len;
          loop_d     = loop;
          lvl_d      = '0;
          step_cnt_d = '0;
          hold_cnt_d = '0;
          state_d    = ST_UP;
        end
      end
      ST_UP: begin
        if (step_event) begin
          step_cnt_d = '0;
          lvl_d      = lvl_q + C_ONE;
          if (lvl_q == LVL_MAX - C_ONE) begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end
        end else if (period_tick) begin
          step_cnt_d = step_cnt_q + P_ONE;
        end
      end
      ST_HOLD: begin
        if (period_tick) begin
          if (hold_cnt_q == hlen_q) begin
            step_cnt_d = '0;
            state_d    = ST_DOWN;
          end else begin
            hold_cnt_d = hold_cnt_q + P_ONE;
          end
        end
      end
      ST_DOWN: begin
        if (step_event) begin
          step_cnt_d = '0;
          lvl_d      = lvl_q - C_ONE;
          if (lvl_q == C_ONE) begin
            done_c  = 1'b1;
            state_d = loop_q ? ST_UP : ST_IDLE;
          end
        end else if (period_tick) begin
          step_cnt_d = step_cnt_q + P_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a start in the same cycle, and
    // clears compare without waiting for a period boundary.
    if (abort) begin
      state_d    = ST_IDLE;
      lvl_d      = '0;
      step_cnt_d = '0;
      hold_cnt_d = '0;
      compare_d  = '0;
      done_c     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lvl_q      <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      tgt_q      <= '0;
      sdiv_q     <= '0;
      hlen_q     <= '0;
      loop_q     <= 1'b0;
      compare_q  <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      tgt_q      <= tgt_d;
      sdiv_q     <= sdiv_d;
      hlen_q     <= hlen_d;
      loop_q     <= loop_d;
      compare_q  <= compare_d;
    end
  end

  assign compare = compare_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_c;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - self-checking bench for pwm_fade_ctrl

module tb_pwm_fade_ctrl;

  localparam int C   = 4;
  localparam int NCH = 3;
  localparam int PL  = 8;
  localparam int P   = 1 << C;
  localparam int M   = P - 1;
  localparam int TW  = NCH * C;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic          loop     = 1'b0;
  logic [TW-1:0] target   = '0;
  logic [PL-1:0] step_div = '0;
  logic [PL-1:0] hold_len = '0;
  logic [TW-1:0] compare;
  logic          period_tick;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int ecount;

  pwm_fade_ctrl #(.CTR_LEN(C), .NCH(NCH), .PRESC_LEN(PL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .loop(loop),
    .target(target), .step_div(step_div), .hold_len(hold_len),
    .compare(compare), .period_tick(period_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the period position is ecount mod P.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecount <= 0;
    else          ecount <= ecount + 1;
  end

  function automatic int scale_ref(input int t, input int l);
    int e;
`ifdef PWM_FADE_GAMMA_EN
    e = (l * l) / P;
`else
    e = l;
`endif
    return (t * (e + 1)) / P;
  endfunction

  // Level after j period ticks since start: ramp up one step per d+1 ticks,
  // hold h+1 ticks at max, ramp down; repeats with period n when looping.
  function automatic int lvl_ref(input int j, input int d, input int h, input bit lp);
    int ramp, n, jj;
    ramp = M * (d + 1);
    n    = 2 * ramp + h + 1;
    jj   = j;
    if (lp) jj = j % n;
    else if (j >= n) return 0;
    if (jj <= ramp)         return jj / (d + 1);
    if (jj <= ramp + h + 1) return M;
    return M - (jj - ramp - h - 1) / (d + 1);
  endfunction

  task automatic idle_check(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      checks++;
      if (period_tick !== ((ecount % P) == P - 1)) begin
        failures++;
        if (failures <= 40) $display("FAIL %s period_tick: got %b expected %b at edge %0d", name, period_tick, (ecount % P) == P - 1, ecount);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || compare !== '0) begin
        failures++;
        if (failures <= 40) $display("FAIL %s idle outputs: got busy=%b done=%b compare=%h expected 0/0/0", name, busy, done, compare);
      end
    end
  endtask

  task automatic run_seq(input string name, input logic [TW-1:0] tgt, input int d, input int h,
                         input bit lp, input int ncyc, input int spur_at, input int abort_at,
                         input int abort_lvl);
    int n, k;
    bit aborted, tick, ab_now;
    logic exp_busy, exp_done;
    logic [TW-1:0] exp_cmp;
    n = 2 * M * (d + 1) + h + 1;
    @(negedge clk);
    target = tgt; step_div = PL'(d); hold_len = PL'(h); loop = lp; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    target = TW'($urandom); step_div = PL'($urandom); hold_len = PL'($urandom); loop = ~lp;
    k = 0;
    aborted = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tick     = ((ecount % P) == P - 1);
      exp_busy = aborted ? 1'b0 : (lp ? 1'b1 : (k < n));
      exp_done = !aborted && tick && (lp ? (((k + 1) % n) == 0) : (k + 1 == n));
      exp_cmp  = '0;
      if (!aborted && k > 0) begin
        for (int ch = 0; ch < NCH; ch++) begin
          exp_cmp[ch*C +: C] = C'(scale_ref(int'(tgt[ch*C +: C]), lvl_ref(k - 1, d, h, lp)));
        end
      end
      checks++;
      if (period_tick !== tick) begin
        failures++;
        if (failures <= 40) $display("FAIL %s period_tick: got %b expected %b at cycle %0d", name, period_tick, tick, c);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        if (failures <= 40) $display("FAIL %s busy: got %b expected %b at cycle %0d", name, busy, exp_busy, c);
      end
      checks++;
      if (done !== exp_done) begin
        failures++;
        if (failures <= 40) $display("FAIL %s done: got %b expected %b at cycle %0d", name, done, exp_done, c);
      end
      checks++;
      if (compare !== exp_cmp) begin
        failures++;
        if (failures <= 40) $display("FAIL %s compare: got %h expected %h at cycle %0d (ticks %0d)", name, compare, exp_cmp, c, k);
      end
      start  = 1'b0;
      abort  = 1'b0;
      ab_now = !aborted && ((c == abort_at) ||
               (abort_lvl >= 0 && k < M * (d + 1) && lvl_ref(k, d, h, lp) == abort_lvl));
      if (ab_now) begin
        abort  = 1'b1;
        start  = 1'b1;
        target = TW'($urandom);
      end else if (c == spur_at) begin
        start  = 1'b1;
        target = TW'($urandom);
      end
      if (tick) k++;
      if (ab_now) aborted = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int seq_cycles(input int d, input int h);
    return (2 * M * (d + 1) + h + 1) * P + 2 * P;
  endfunction

  task automatic test_reset();
    int first_tick;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (compare !== '0 || busy !== 1'b0 || done !== 1'b0 || period_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: got compare=%h busy=%b done=%b tick=%b expected all 0", compare, busy, done, period_tick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    first_tick = -1;
    for (int c = 1; c <= P && first_tick < 0; c++) begin
      @(negedge clk);
      if (period_tick === 1'b1) first_tick = c;
    end
    checks++;
    if (first_tick != P - 1) begin
      failures++;
      $display("FAIL reset first_tick: got clock %0d expected clock %0d", first_tick, P - 1);
    end
    idle_check("reset_idle", 3 * P);
  endtask

  task automatic test_full_fade();
    run_seq("full_fade", {4'd0, 4'd8, 4'd15}, 0, 0, 1'b0, seq_cycles(0, 0), -1, -1, -1);
  endtask

  task automatic test_abort();
    run_seq("abort", {4'd0, 4'd8, 4'd15}, 0, 0, 1'b0, 20 * P, -1, -1, 6);
  endtask

  task automatic test_start_while_busy();
    run_seq("start_busy", {4'd3, 4'd9, 4'd12}, 0, 1, 1'b0, seq_cycles(0, 1), 5 * P, -1, -1);
  endtask

  task automatic test_loop();
    int nc;
    nc = (2 * (2 * M + 1) + 12) * P;
    run_seq("loop", {4'd15, 4'd5, 4'd10}, 0, 0, 1'b1, nc, 40 * P + 3, nc - P, -1);
  endtask

  task automatic test_slow_steps();
    run_seq("slow_steps", {4'd0, 4'd8, 4'd15}, 3, 2, 1'b0, seq_cycles(3, 2), -1, -1, -1);
  endtask

  task automatic test_random();
    int d, h;
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(2, 0);
      h = $urandom_range(3, 0);
      run_seq("random", TW'($urandom), d, h, 1'b0, seq_cycles(d, h), $urandom_range(60, 10), -1, -1);
    end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle_check("abort_idle", 2 * P);
  endtask

  task automatic test_reset_mid();
    run_seq("pre_reset", {4'd15, 4'd15, 4'd15}, 0, 0, 1'b0, 20 * P, -1, -1, -1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (compare !== '0 || busy !== 1'b0 || done !== 1'b0 || period_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid outputs: got compare=%h busy=%b done=%b tick=%b expected all 0", compare, busy, done, period_tick);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("reset_mid_idle", 3 * P);
  endtask

  initial begin
    test_reset();
    test_full_fade();
    test_abort();
    idle_check("after_abort", 2 * P);
    test_start_while_busy();
    test_loop();
    test_slow_steps();
    test_random();
    test_abort_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
